cic_comb_decim: RTL and testbench

Decimating comb section of the CIC decimation chain: consumes the full-rate output of the integrator cascade, keeps one sample in every R accepted samples, and passes it through N registered comb (differentiator) stages of differential delay M. Output is the low-rate CIC result with a one-cycle valid strobe, ready for the compensation FIR. All arithmetic wraps modulo 2^W, which is required for CIC correctness when W ≥ input width + N·log2(R·M).

---
 rtl/cic_pkg.sv | 22 ++
 rtl/comb_stage.sv | 54 +++++
 rtl/cic_comb_decim.sv | 90 +++++++++
 tb/tb_cic_comb_decim.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants for the CIC decimation chain (integrator cascade and comb section).
package cic_pkg;

   localparam int CIC_W = 10;
   localparam int CIC_N = 3;
   localparam int CIC_M = 1;
   localparam int CIC_R = 8;

   // Bits needed to count 0..v-1, never less than one.
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/comb_stage.sv
// One registered CIC comb (differentiator): y = x - x[n-M], advancing only on valid tokens.
module comb_stage
   import cic_pkg::*;
#(
   parameter int W = CIC_W,
   parameter int M = CIC_M
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] x,
   input  logic         in_vld,
   output logic [W-1:0] y,
   output logic         out_vld
);

   logic [W-1:0] dly_q [M];
   logic [W-1:0] dly_d [M];
   logic [W-1:0] y_q;
   logic [W-1:0] y_d;
   logic         vld_q;
   logic         vld_d;

   always_comb begin
      dly_d = dly_q;
      y_d   = y_q;
      vld_d = in_vld;
      if (in_vld) begin
         // Modulo-2^W subtraction is what keeps the CIC exact despite integrator wrap.
         y_d      = x - dly_q[M-1];
         dly_d[0] = x;
         for (int i = 1; i < M; i++) begin
            dly_d[i] = dly_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < M; i++) begin
            dly_q[i] <= '0;
         end
         y_q   <= '0;
         vld_q <= 1'b0;
      end else begin
         dly_q <= dly_d;
         y_q   <= y_d;
         vld_q <= vld_d;
      end
   end

   assign y       = y_q;
   assign out_vld = vld_q;

endmodule

// File: rtl/cic_comb_decim.sv
// Decimating comb section: keep one of every R accepted samples, then N comb stages of delay M.
module cic_comb_decim
   import cic_pkg::*;
#(
   parameter int W = CIC_W,
   parameter int N = CIC_N,
   parameter int M = CIC_M,
   parameter int R = CIC_R
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         din_vld,
   input  logic         sync,
   output logic [W-1:0] dout,
   output logic         dout_vld
);

   localparam int CW = clog2(R);
   localparam logic [CW-1:0] CNT_LAST  = CW'(R - 1);
   localparam logic [CW-1:0] CNT_AFTER = (R == 1) ? '0 : CW'(1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [W-1:0]  cap_q;
   logic [W-1:0]  cap_d;
   logic          cap_vld_q;
   logic          cap_vld_d;
   logic          dec;

   always_comb begin
      cnt_d     = cnt_q;
      cap_d     = cap_q;
      cap_vld_d = 1'b0;
      dec       = 1'b0;
      if (din_vld) begin
         if (sync) begin
            // The sync sample becomes phase index 0.
            dec   = (R == 1);
            cnt_d = CNT_AFTER;
         end else begin
            dec   = (cnt_q == CNT_LAST);
            cnt_d = dec ? '0 : cnt_q + CW'(1);
         end
         if (dec) begin
            cap_d     = din;
            cap_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         cap_q     <= '0;
         cap_vld_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         cap_q     <= cap_d;
         cap_vld_q <= cap_vld_d;
      end
   end

   logic [W-1:0] stg_dat [N+1];
   logic [N:0]   stg_vld;

   assign stg_dat[0] = cap_q;
   assign stg_vld[0] = cap_vld_q;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_comb
         comb_stage #(
            .W (W),
            .M (M)
         ) u_comb (
            .clk     (clk),
            .rst     (rst),
            .x       (stg_dat[gi]),
            .in_vld  (stg_vld[gi]),
            .y       (stg_dat[gi+1]),
            .out_vld (stg_vld[gi+1])
         );
      end
   endgenerate

   // The last stage register is the output register, so dout only moves with a strobe.
   assign dout     = stg_dat[N];
   assign dout_vld = stg_vld[N];

endmodule

// File: tb/tb_cic_comb_decim.sv
// Scoreboard bench: four parameter sets, each checked against a binomial-form CIC comb model.
module tb_cic_comb_decim;

   localparam int W = 10;
   localparam int NCFG = 4;

   typedef struct {
      int         cyc;
      logic [W-1:0] val;
   } exp_t;

   logic clk;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic [NCFG-1:0] done = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int binom(input int n, input int k);
      int r;
      r = 1;
      for (int i = 0; i < k; i++) begin
         r = r * (n - i) / (i + 1);
      end
      return r;
   endfunction

   generate
      for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
         localparam int N = (gi == 0) ? 3 : (gi == 1) ? 2 : (gi == 2) ? 1 : 2;
         localparam int M = (gi == 3) ? 2 : 1;
         localparam int R = (gi == 0) ? 8 : (gi == 1) ? 4 : (gi == 2) ? 1 : 3;

         logic         rst;
         logic [W-1:0] din;
         logic         din_vld;
         logic         sync;
         logic [W-1:0] dout;
         logic         dout_vld;

         exp_t         q[$];
         int           hist[$];
         int           k;
         logic [W-1:0] last;

         cic_comb_decim #(
            .W (W),
            .N (N),
            .M (M),
            .R (R)
         ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .din      (din),
            .din_vld  (din_vld),
            .sync     (sync),
            .dout     (dout),
            .dout_vld (dout_vld)
         );

         // Drive one cycle and advance the reference model for the sample it carries.
         task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
            int   acc;
            int   idx;
            exp_t e;
            @(posedge clk);
            #1;
            din     = d;
            din_vld = v;
            sync    = s;
            if (v) begin
               if (s) k = 0;
               if ((k % R) == R - 1) begin
                  hist.push_back(int'($signed(d)));
                  acc = 0;
                  for (int j = 0; j <= N; j++) begin
                     idx = hist.size() - 1 - j * M;
                     if (idx >= 0)
                        acc += ((j % 2) ? -1 : 1) * binom(N, j) * hist[idx];
                  end
                  e.cyc = cyc + 1 + N;
                  e.val = acc[W-1:0];
                  q.push_back(e);
               end
               k++;
            end
         endtask

         task automatic do_reset();
            @(posedge clk);
            #1;
            din_vld = 1'b0;
            sync    = 1'b0;
            #2;
            rst = 1'b1;
            q.delete();
            hist.delete();
            k = 0;
            #1;
            checks++;
            if (dout !== '0 || dout_vld !== 1'b0) begin
               errors++;
               $display("FAIL cfg%0d async_reset: dout=%0h dout_vld=%b, required 0/0", gi, dout, dout_vld);
            end
            @(posedge clk);
            #1;
            rst = 1'b0;
         endtask

         initial begin
            rst = 1'b1;
            din = '0;
            din_vld = 1'b0;
            sync = 1'b0;
            k = 0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            if (gi == 0) begin
               // Step: constant 7 from reset.
               repeat (60) drive(1'b1, 1'b0, W'(7));
            end else if (gi == 1) begin
               // Impulse on decimated index 0, continuous then gapped, then a sync at cnt=2.
               while (k < 24) drive(1'b1, 1'b0, (k == 3) ? W'(5) : W'(0));
               drive(1'b1, 1'b0, W'(0));
               do_reset();
               while (k < 24) begin
                  if ($urandom % 3 != 0) drive(1'b1, 1'b0, (k == 3) ? W'(5) : W'(0));
                  else drive(1'b0, 1'b0, W'(0));
               end
               do_reset();
               drive(1'b1, 1'b0, W'(11));
               drive(1'b1, 1'b0, W'(22));
               drive(1'b0, 1'b1, W'(99));
               drive(1'b1, 1'b1, W'(33));
               for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, W'(40 + i));
            end else if (gi == 2) begin
               // Wraparound: 511 - (-512) must wrap to -1.
               drive(1'b1, 1'b0, W'(-512));
               drive(1'b1, 1'b0, W'(511));
               drive(1'b1, 1'b0, W'(511));
               drive(1'b1, 1'b0, W'(-512));
            end
            for (int i = 0; i < 400; i++) begin
               if ($urandom % 150 == 0) do_reset();
               else drive(($urandom % 4) != 0, ($urandom % 12) == 0, W'($urandom));
            end
            repeat (N + 3) drive(1'b0, 1'b0, W'(0));
            checks++;
            if (q.size() != 0) begin
               errors++;
               $display("FAIL cfg%0d drain: %0d expected strobes outstanding, required 0", gi, q.size());
            end
            done[gi] = 1'b1;
         end

         always @(negedge clk) begin
            exp_t e;
            if (rst) begin
               checks++;
               if (dout !== '0 || dout_vld !== 1'b0) begin
                  errors++;
                  $display("FAIL cfg%0d reset_state: dout=%0h dout_vld=%b, required 0/0", gi, dout, dout_vld);
               end
               last = '0;
            end else begin
               while (q.size() != 0 && q[0].cyc < cyc) begin
                  e = q.pop_front();
                  errors++;
                  $display("FAIL cfg%0d missing_strobe: none at cycle %0d, required dout=%0d", gi, e.cyc, $signed(e.val));
               end
               checks++;
               if (dout_vld === 1'b1) begin
                  if (q.size() == 0 || q[0].cyc != cyc) begin
                     errors++;
                     $display("FAIL cfg%0d unexpected_strobe: dout_vld=1 at cycle %0d, required 0", gi, cyc);
                  end else begin
                     e = q.pop_front();
                     if (dout !== e.val) begin
                        errors++;
                        $display("FAIL cfg%0d dout: got %0d at cycle %0d, required %0d", gi, $signed(dout), cyc, $signed(e.val));
                     end
                  end
                  last = dout;
               end else if (dout_vld !== 1'b0 || dout !== last) begin
                  errors++;
                  $display("FAIL cfg%0d hold: dout=%0h dout_vld=%b at cycle %0d, required %0h/0", gi, dout, dout_vld, cyc, last);
               end
            end
         end
      end
   endgenerate

   initial begin
      for (int i = 0; i < 20000 && done != {NCFG{1'b1}}; i++) @(posedge clk);
      if (done != {NCFG{1'b1}}) begin
         errors++;
         $display("FAIL timeout: done=%b, required all ones", done);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
